// File: rtl/alu_muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
// Signedness is decided from funct3 alone, so the same helpers condition operands and results.
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_signed_a(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_signed_b(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_div(input md_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_muldiv_sign_adjust.sv
// Conditional two's-complement negate: magnitude extraction on the way in,
// sign restoration on the way out.
module md_sign_adjust #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] result_o
);

    assign result_o = negate_i ? (WIDTH'(0) - value_i) : value_i;

endmodule

// File: rtl/alu_muldiv.sv
// Radix-2 iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle,
// fixed DATA_WIDTH-cycle latency, valid/ready on both sides, flush aborts in-flight work.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    MDResult,
    output logic                     busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t         state_q, state_d;
    md_op_e         op_q, op_d, op_in;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           res_neg_q, res_neg_d;
    logic           rem_neg_q, rem_neg_d;
    logic           divzero_q, divzero_d;

    logic           load, step, finish;
    logic           sign_a, sign_b;
    logic [W-1:0]   mag_a, mag_b;

    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W-1:0]   div_diff;
    logic           div_ok;
    logic [W-1:0]   step_hi, step_lo;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix, rem_fix;
    logic [W-1:0]   final_res;

    assign op_in  = md_op_e'(Operation[2:0]);
    assign sign_a = SrcA[W-1] & is_signed_a(op_in);
    assign sign_b = SrcB[W-1] & is_signed_b(op_in);

    md_sign_adjust #(.WIDTH(W)) u_mag_a (.value_i(SrcA), .negate_i(sign_a), .result_o(mag_a));
    md_sign_adjust #(.WIDTH(W)) u_mag_b (.value_i(SrcB), .negate_i(sign_b), .result_o(mag_b));

    // Multiply: hi:lo holds partial product above the not-yet-consumed multiplier bits.
    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {hi_q, lo_q[W-1]};
    assign div_ok    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = W'(div_shift - {1'b0, opnd_q});

    always_comb begin
        if (is_div(op_q)) begin
            step_hi = div_ok ? div_diff : div_shift[W-1:0];
            step_lo = {lo_q[W-2:0], div_ok};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end
    end

    md_sign_adjust #(.WIDTH(2*W)) u_fix_prod (
        .value_i({step_hi, step_lo}), .negate_i(res_neg_q), .result_o(prod_fix));
    md_sign_adjust #(.WIDTH(W)) u_fix_quot (
        .value_i(step_lo), .negate_i(res_neg_q), .result_o(quot_fix));
    md_sign_adjust #(.WIDTH(W)) u_fix_rem (
        .value_i(step_hi), .negate_i(rem_neg_q), .result_o(rem_fix));

    // A zero divisor leaves |SrcA| as remainder, so only the quotient needs an override.
    always_comb begin
        case (op_q)
            MD_MUL:                        final_res = prod_fix[W-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_res = prod_fix[2*W-1:W];
            MD_DIV, MD_DIVU:               final_res = divzero_q ? '1 : quot_fix;
            default:                       final_res = rem_fix;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt_q == CW'(1)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        op_d      = op_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        divzero_d = divzero_q;
        result_d  = result_q;
        if (load) begin
            op_d      = op_in;
            opnd_d    = is_div(op_in) ? mag_b : mag_a;
            lo_d      = is_div(op_in) ? mag_a : mag_b;
            hi_d      = '0;
            cnt_d     = CW'(W);
            res_neg_d = sign_a ^ sign_b;
            rem_neg_d = sign_a;
            divzero_d = (SrcB == '0);
        end else if (step) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CW'(1);
            if (finish) result_d = final_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state registers use non-blocking assignment and reset asynchronously to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= MD_MUL;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            divzero_q <= 1'b0;
            result_q  <= '0;
        end else begin
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            divzero_q <= divzero_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign MDResult  = result_q;

endmodule
